// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache feeding the IF stage.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STAT_EN.
module icache_fetch #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  pc_valid,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  output logic                  IC_Instr_valid,
  output logic [31:0]           IC_Instr,
  output logic                  busy,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_data
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, MISS, DROP} state_e;

  state_e                  state_q, state_d;
  logic                    instr_valid_q, instr_valid_d;
  logic [31:0]             instr_q, instr_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    busy_q, busy_d;
  logic                    fill_en;

  logic [LINES-1:0]        valid_q;
  logic [TAG_BITS-1:0]     tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];

  logic [INDEX_BITS-1:0]   pc_idx, fill_idx;
  logic [TAG_BITS-1:0]     pc_tag, fill_tag;
  logic                    hit;
  logic                    unused_pc_bits;

  assign pc_idx         = pc[INDEX_BITS+1:2];
  assign pc_tag         = pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign fill_idx       = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag       = mem_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit            = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign unused_pc_bits = ^pc[1:0];

  always_comb begin
    state_d       = state_q;
    instr_valid_d = 1'b0;
    instr_d       = instr_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    busy_d        = busy_q;
    fill_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && pc_valid) begin
          if (hit) begin
            instr_valid_d = 1'b1;
            instr_d       = data_mem[pc_idx];
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {pc[ADDR_WIDTH-1:2], 2'b00};
            busy_d     = 1'b1;
            state_d    = MISS;
          end
        end
      end
      MISS: begin
        // The returning word always fills the line; flush only hides delivery.
        if (mem_valid) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
          if (!flush) begin
            instr_valid_d = 1'b1;
            instr_d       = mem_data;
          end
        end else if (flush) begin
          mem_req_d = 1'b0;
          state_d   = DROP;
        end
      end
      DROP: begin
        if (mem_valid) begin
          fill_en = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      busy_q        <= 1'b0;
      valid_q       <= '0;
    end else if (rdy) begin
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      busy_q        <= busy_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_data;
    end
  end

  assign IC_Instr_valid = instr_valid_q;
  assign IC_Instr       = instr_q;
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign busy           = busy_q;

`ifdef ICACHE_STAT_EN
  logic        hit_acc, miss_acc;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign hit_acc  = (state_q == IDLE) && !flush && pc_valid && hit;
  assign miss_acc = (state_q == IDLE) && !flush && pc_valid && !hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      if (hit_acc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_acc) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed plus randomized bench for icache_fetch against a line-table and
// pending-request reference model.
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        pc_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        IC_Instr_valid;
  logic [31:0] IC_Instr;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  icache_fetch #(.INDEX_BITS(6), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc_valid(pc_valid), .pc(pc), .flush(flush),
    .IC_Instr_valid(IC_Instr_valid), .IC_Instr(IC_Instr), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data)
`ifdef ICACHE_STAT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a table of 64 lines plus one outstanding request.
  bit          m_v    [64];
  logic [23:0] m_tag  [64];
  logic [31:0] m_data [64];
  bit          e_valid, e_busy, e_req, e_cancel;
  logic [31:0] e_instr, e_addr, e_hits, e_misses;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
    e_valid = 0; e_busy = 0; e_req = 0; e_cancel = 0;
    e_instr = 0; e_addr = 0; e_hits = 0; e_misses = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] p, input bit f,
                            input bit mv, input logic [31:0] md, input bit r);
    int idx;
    logic [23:0] tg;
    if (!r) return;
    e_valid = 0;
    if (!e_busy) begin
      if (!f && v) begin
        idx = int'((p / 4) % 64);
        tg  = p[31:8];
        if (m_v[idx] && m_tag[idx] == tg) begin
          e_valid = 1; e_instr = m_data[idx]; e_hits = e_hits + 1;
        end else begin
          e_req = 1; e_busy = 1; e_cancel = 0;
          e_addr = p & 32'hFFFF_FFFC; e_misses = e_misses + 1;
        end
      end
    end else if (mv) begin
      idx = int'((e_addr / 4) % 64);
      m_v[idx] = 1; m_tag[idx] = e_addr[31:8]; m_data[idx] = md;
      if (!e_cancel && !f) begin
        e_valid = 1; e_instr = md;
      end
      e_req = 0; e_busy = 0; e_cancel = 0;
    end else if (f) begin
      e_req = 0; e_cancel = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, {31'd0, IC_Instr_valid}, {31'd0, e_valid});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({tag, ".req"}, {31'd0, mem_req}, {31'd0, e_req});
    if (e_req) chk({tag, ".addr"}, mem_addr, e_addr);
    if (e_valid) chk({tag, ".instr"}, IC_Instr, e_instr);
`ifdef ICACHE_STAT_EN
    chk({tag, ".hits"}, hit_cnt, e_hits);
    chk({tag, ".misses"}, miss_cnt, e_misses);
`endif
  endtask

  task automatic step(input string tag, input bit v, input logic [31:0] p, input bit f,
                      input bit mv, input logic [31:0] md, input bit r);
    @(negedge clk);
    pc_valid = v; pc = p; flush = f; mem_valid = mv; mem_data = md; rdy = r;
    model_step(v, p, f, mv, md, r);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    bit v, f, mv, r;
    logic [31:0] p;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    chk("reset.instr", IC_Instr, 32'h0);
    chk("reset.addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Cold miss then hit
    step("cold_miss", 1, 32'h0000_0000, 0, 0, 0, 1);
    step("cold_wait", 0, 32'h0, 0, 0, 0, 1);
    step("cold_fill", 0, 32'h0, 0, 1, 32'h0000_0093, 1);
    step("idle", 0, 32'h0, 0, 0, 0, 1);
    step("hit0", 1, 32'h0000_0000, 0, 0, 0, 1);
    step("hit0_after", 0, 32'h0, 0, 0, 0, 1);

    // Conflict on index 0
    step("conf_miss", 1, 32'h0000_0100, 0, 0, 0, 1);
    step("conf_fill", 0, 32'h0, 0, 1, 32'h1234_5678, 1);
    step("conf_hit", 1, 32'h0000_0102, 0, 0, 0, 1);
    step("conf_remiss", 1, 32'h0000_0000, 0, 0, 0, 1);
    step("conf_refill", 0, 32'h0, 0, 1, 32'h0000_0093, 1);

    // Flush mid-miss
    step("fl_miss", 1, 32'h0000_0008, 0, 0, 0, 1);
    step("fl_wait", 0, 32'h0, 0, 0, 0, 1);
    step("fl_flush", 0, 32'h0, 1, 0, 0, 1);
    step("fl_drop", 1, 32'h0000_0010, 0, 0, 0, 1);
    step("fl_resp", 0, 32'h0, 0, 1, 32'h0000_CAFE, 1);
    step("fl_hit", 1, 32'h0000_0008, 0, 0, 0, 1);
    step("flush_idle", 1, 32'h0000_0008, 1, 0, 0, 1);

    // Stall during MISS with ignored mem_valid pulses, then a stalled result
    step("st_miss", 1, 32'h0000_0020, 0, 0, 0, 1);
    step("st_stall0", 0, 32'h0, 0, 1, 32'hDEAD_0000, 0);
    step("st_stall1", 0, 32'h0, 1, 1, 32'hDEAD_0001, 0);
    step("st_stall2", 0, 32'h0, 0, 1, 32'hDEAD_0002, 0);
    step("st_fill", 0, 32'h0, 0, 1, 32'hBEEF_0020, 1);
    step("st_hold", 0, 32'h0, 0, 0, 0, 0);
    step("st_release", 0, 32'h0, 0, 0, 0, 1);

    // Flush coincident with response
    step("fr_miss", 1, 32'h0000_0040, 0, 0, 0, 1);
    step("fr_both", 0, 32'h0, 1, 1, 32'h0000_4040, 1);
    step("fr_hit", 1, 32'h0000_0040, 0, 0, 0, 1);

    // Reset mid-miss, late response ignored, prior fills gone
    step("rm_miss", 1, 32'h0000_0044, 0, 0, 0, 1);
    @(negedge clk);
    pc_valid = 0; mem_valid = 0; flush = 0;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all("rm_async");
    @(negedge clk);
    rst = 1'b1;
    step("rm_late", 0, 32'h0, 0, 1, 32'h0BAD_0BAD, 1);
    step("rm_remiss", 1, 32'h0000_0000, 0, 0, 0, 1);
    step("rm_fill", 0, 32'h0, 0, 1, 32'h0000_0013, 1);

    // Randomized traffic over a small address pool to force conflicts
    for (int n = 0; n < 600; n++) begin
      p  = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      v  = e_busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      f  = ($urandom_range(0, 9) == 0);
      mv = e_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 5) != 0);
      step("rand", v, p, f, mv, $urandom, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache directly upstream of the IF stage.
- Accepts a fetch PC, returns one 32-bit instruction on IC_Instr/IC_Instr_valid.
- On a miss, fetches the word from the memory controller and fills the line.
- Supports a flush, driven by the branch-mispredict redirect, that cancels an in-flight fetch.

Parameters:
INDEX_BITS, 6, log2 of line count (one 32-bit word per line; 64 lines)
ADDR_WIDTH, 32, byte-address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
rdy  input  1  global ready; when 0 all state, including registered outputs, holds
pc_valid  input  1  fetch request present this cycle
pc  input  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
flush  input  1  drop any pending request/response
IC_Instr_valid  output  1  one-cycle pulse: IC_Instr holds a valid instruction
IC_Instr  output  32  fetched instruction
busy  output  1  1 while a miss is outstanding; upstream must not present a new pc
mem_req  output  1  word-read request to memory controller, held until mem_valid
mem_addr  output  ADDR_WIDTH  word-aligned request address ({pc[31:2],2'b00})
mem_valid  input  1  memory controller returns mem_data this cycle
mem_data  input  32  returned instruction word

Behaviour:
- Address split: index = pc[INDEX_BITS+1:2]; tag = pc[ADDR_WIDTH-1:INDEX_BITS+2].
- Storage: valid bit, tag and data per line.
- Reset (rst=0, async): all valid bits clear; state=IDLE; IC_Instr_valid=0, IC_Instr=0, mem_req=0, mem_addr=0, busy=0.
- Data and tag arrays need no reset.
- All actions below apply only in cycles with rdy=1.
- IDLE, pc_valid=1, flush=0, hit: next cycle IC_Instr_valid=1 and IC_Instr=line data (latency 1).
- IDLE, pc_valid=1, flush=0, miss:
  - Latch request address.
  - Next cycle: mem_req=1, mem_addr=aligned pc, busy=1; state=MISS.
- MISS, mem_valid=1:
  - Write data, tag and valid=1 into the line.
  - Next cycle: IC_Instr_valid=1, IC_Instr=mem_data, mem_req=0, busy=0; state=IDLE.
- MISS, mem_valid=0: hold mem_req and mem_addr stable.
- IC_Instr_valid is a one-cycle pulse; it is 0 in every other cycle.
- flush=1 in IDLE: pc_valid ignored; no output next cycle.
- flush=1 in MISS with mem_valid=0:
  - Deassert mem_req next cycle; state=DROP; busy stays 1.
  - In DROP, the next mem_valid is consumed: the line is still filled, IC_Instr_valid is not raised, state returns to IDLE.
- flush=1 in the same cycle as mem_valid:
  - Line is filled; IC_Instr_valid suppressed; state=IDLE.
- flush has priority over pc_valid and over result delivery in all states.
- pc_valid while busy=1 is a protocol violation and is ignored.
- Replacement: a miss on a valid line with a different tag overwrites it.
- Reset during MISS/DROP returns to IDLE immediately; a late mem_valid after reset is ignored in IDLE.

Optional Feature:
- Macro: ICACHE_STAT_EN.
- When defined, two output ports are added:
  - hit_cnt [31:0]: increments once per IDLE hit acceptance.
  - miss_cnt [31:0]: increments once per miss entering MISS.
- Both counters reset to 0, wrap modulo 2^32, hold when rdy=0, and are not affected by flush.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Cold miss: after reset, pc=0x0000_0000 -> mem_req=1, mem_addr=0x0; mem_valid with mem_data=0x0000_0093 -> next cycle IC_Instr_valid=1, IC_Instr=0x00000093, busy=0.
- Hit: repeat pc=0x0 -> IC_Instr=0x00000093 one cycle later; mem_req stays 0.
- Conflict: pc=0x100 (same index 0, tag 1) -> miss, mem_addr=0x100. Fill 0x12345678, then pc=0x0 -> miss again.
- Flush mid-miss: pc=0x8 miss, flush two cycles later -> mem_req drops. Subsequent mem_valid produces no IC_Instr_valid; the next pc=0x8 hits.
- Stall: rdy=0 for 3 cycles during MISS with mem_valid pulses ignored -> outputs frozen; resumes correctly once rdy=1.
- Reset mid-miss: rst=0 while busy=1 -> immediately busy=0, mem_req=0. Prior fill at 0x0 invalidated: pc=0x0 misses.
